// File: rtl/reg_file_cmd_ctrl.sv
// reg_file_cmd_ctrl: command front-end for the register file.
// Host requests are queued in a small command FIFO and issued to the
// register file one at a time. Read data (or a timeout or range error)
// comes back on a valid/ready response channel.
// Optional build macro: REG_FILE_CMD_WRITE_ACK_EN. When defined, every write
// also produces a response (rsp_err = 1 for a dropped out-of-range write).
module reg_file_cmd_ctrl #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int ADDRESS    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [ADDRESS-1:0] req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    output logic [WIDTH-1:0]   rf_in_data,
    output logic [ADDRESS-1:0] rf_address,
    output logic               rf_wr_en,
    output logic               rf_rd_en,
    input  logic [WIDTH-1:0]   rf_out_data,
    input  logic               rf_valid_out,
    output logic               busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMO_W = $clog2(RD_TIMEOUT);

    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST      = TMO_W'(RD_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    // Command FIFO storage
    logic               fifo_wr_q   [FIFO_DEPTH];
    logic [ADDRESS-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [1:0]         state_q, state_d;
    logic               cmd_write_q, cmd_write_d;
    logic [ADDRESS-1:0] cmd_addr_q, cmd_addr_d;
    logic [WIDTH-1:0]   cmd_data_q, cmd_data_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic [WIDTH-1:0]   rf_in_data_q, rf_in_data_d;
    logic [ADDRESS-1:0] rf_address_q, rf_address_d;
    logic               rf_wr_en_q, rf_wr_en_d;
    logic               rf_rd_en_q, rf_rd_en_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic cmd_in_range;

    // A full FIFO refuses pushes even when a pop happens in the same cycle,
    // so req_ready depends only on the registered count.
    assign fifo_full    = (count_q == FIFO_FULL_CNT);
    assign fifo_empty   = (count_q == '0);
    assign req_ready    = !fifo_full;
    assign push         = req_valid && !fifo_full;
    assign pop          = (state_q == ST_IDLE) && !fifo_empty;
    assign cmd_in_range = (32'(cmd_addr_q) < 32'(DEPTH));

    assign rf_in_data = rf_in_data_q;
    assign rf_address = rf_address_q;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_rd_en   = rf_rd_en_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = !fifo_empty || (state_q != ST_IDLE);

    // Queue payload write; storage needs no reset because count gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr_q[wr_ptr_q]   <= req_write;
            fifo_addr_q[wr_ptr_q] <= req_addr;
            fifo_data_q[wr_ptr_q] <= req_wdata;
        end
    end

    // Next-state for the FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Issue FSM: pop a command, strobe the register file, collect the reply
    always_comb begin
        state_d      = state_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_data_d   = cmd_data_q;
        tmo_cnt_d    = tmo_cnt_q;
        rf_in_data_d = rf_in_data_q;
        rf_address_d = rf_address_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    cmd_write_d = fifo_wr_q[rd_ptr_q];
                    cmd_addr_d  = fifo_addr_q[rd_ptr_q];
                    cmd_data_d  = fifo_data_q[rd_ptr_q];
                    state_d     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (cmd_in_range) begin
                    rf_address_d = cmd_addr_q;
                    if (cmd_write_q) begin
                        rf_wr_en_d   = 1'b1;
                        rf_in_data_d = cmd_data_q;
`ifdef REG_FILE_CMD_WRITE_ACK_EN
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = '0;
                        rsp_err_d    = 1'b0;
                        state_d      = ST_RESP;
`else
                        state_d      = ST_IDLE;
`endif
                    end else begin
                        rf_rd_en_d = 1'b1;
                        tmo_cnt_d  = '0;
                        state_d    = ST_WAIT_RD;
                    end
                end else if (cmd_write_q) begin
`ifdef REG_FILE_CMD_WRITE_ACK_EN
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
`else
                    state_d     = ST_IDLE;
`endif
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end
            end

            ST_WAIT_RD: begin
                if (rf_valid_out) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rf_out_data;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset flushes the FIFO and drops any pending work
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_data_q   <= '0;
            tmo_cnt_q    <= '0;
            rf_in_data_q <= '0;
            rf_address_q <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_data_q   <= cmd_data_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rf_in_data_q <= rf_in_data_d;
            rf_address_q <= rf_address_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// tb_reg_file_cmd_ctrl: directed bench for reg_file_cmd_ctrl (default build,
// write acknowledge disabled). The DUT is built with DEPTH = 12 so that
// addresses 12..15 are out of range. The register file side is driven by hand.
module tb_reg_file_cmd_ctrl;

    localparam int WIDTH   = 32;
    localparam int ADDRESS = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [ADDRESS-1:0] req_addr;
    logic [WIDTH-1:0]   req_wdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_err;
    logic [WIDTH-1:0]   rf_in_data;
    logic [ADDRESS-1:0] rf_address;
    logic               rf_wr_en;
    logic               rf_rd_en;
    logic [WIDTH-1:0]   rf_out_data;
    logic               rf_valid_out;
    logic               busy;

    int checks    = 0;
    int errors    = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int wr_log[$];

    logic acc;
    logic saw_rsp;
    int   start_wr;
    int   start_rd;
    int   exp_addr[5] = '{1, 2, 4, 5, 6};

    reg_file_cmd_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(12),
        .ADDRESS(ADDRESS),
        .FIFO_DEPTH(4),
        .RD_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .rf_in_data(rf_in_data),
        .rf_address(rf_address),
        .rf_wr_en(rf_wr_en),
        .rf_rd_en(rf_rd_en),
        .rf_out_data(rf_out_data),
        .rf_valid_out(rf_valid_out),
        .busy(busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Advance to the next falling edge and log any strobe seen in that cycle
    task automatic tick();
        @(negedge clk);
        if (rf_wr_en === 1'b1) begin
            wr_pulses++;
            wr_log.push_back(int'(rf_address));
        end
        if (rf_rd_en === 1'b1) begin
            rd_pulses++;
        end
    endtask

    // One comparison point
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one request; returns at the falling edge after the accepting edge
    task automatic applyStimulus(input logic wr, input logic [ADDRESS-1:0] a,
                                 input logic [WIDTH-1:0] d, output logic accepted);
        accepted  = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        for (int n = 0; n < 40 && !accepted; n++) begin
            if (req_ready) accepted = 1'b1;
            tick();
        end
        req_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;
        rf_out_data  = '0;
        rf_valid_out = 1'b0;
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_wr_en", rf_wr_en, 0);
        checkOutput("rst_rd_en", rf_rd_en, 0);
        checkOutput("rst_address", rf_address, 0);
        checkOutput("rst_in_data", rf_in_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_req_ready", req_ready, 1);
        rst = 1'b0;
        tick();

        $display("[TB] write addr 3");
        applyStimulus(1'b1, 4'd3, 32'hDEADBEEF, acc);
        checkOutput("wr_accept", acc, 1);
        checkOutput("wr_busy_queued", busy, 1);
        tick();
        checkOutput("wr_not_early", rf_wr_en, 0);
        tick();
        checkOutput("wr_strobe", rf_wr_en, 1);
        checkOutput("wr_no_rd", rf_rd_en, 0);
        checkOutput("wr_address", rf_address, 3);
        checkOutput("wr_data", rf_in_data, 32'hDEADBEEF);
        tick();
        checkOutput("wr_strobe_end", rf_wr_en, 0);
        checkOutput("wr_addr_hold", rf_address, 3);
        checkOutput("wr_idle", busy, 0);
        checkOutput("wr_no_rsp", rsp_valid, 0);
        checkOutput("wr_pulse_count", wr_pulses, 1);

        $display("[TB] read addr 3");
        applyStimulus(1'b0, 4'd3, '0, acc);
        tick();
        tick();
        checkOutput("rd_strobe", rf_rd_en, 1);
        checkOutput("rd_address", rf_address, 3);
        tick();
        checkOutput("rd_strobe_end", rf_rd_en, 0);
        checkOutput("rd_rsp_not_early", rsp_valid, 0);
        rf_valid_out = 1'b1;
        rf_out_data  = 32'hDEADBEEF;
        tick();
        rf_valid_out = 1'b0;
        rf_out_data  = '0;
        checkOutput("rd_rsp_valid", rsp_valid, 1);
        checkOutput("rd_rsp_data", rsp_data, 32'hDEADBEEF);
        checkOutput("rd_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("rd_rsp_done", rsp_valid, 0);
        checkOutput("rd_pulse_count", rd_pulses, 1);

        $display("[TB] read timeout addr 7");
        applyStimulus(1'b0, 4'd7, '0, acc);
        repeat (9) tick();
        checkOutput("tmo_not_early", rsp_valid, 0);
        tick();
        checkOutput("tmo_rsp_valid", rsp_valid, 1);
        checkOutput("tmo_rsp_err", rsp_err, 1);
        checkOutput("tmo_rsp_data", rsp_data, 0);
        checkOutput("tmo_rd_pulses", rd_pulses, 2);

        $display("[TB] fill FIFO behind stalled response");
        applyStimulus(1'b1, 4'd1, 32'h11111111, acc);
        applyStimulus(1'b1, 4'd2, 32'h22222222, acc);
        applyStimulus(1'b1, 4'd4, 32'h44444444, acc);
        applyStimulus(1'b1, 4'd5, 32'h55555555, acc);
        checkOutput("fill_4th_accept", acc, 1);
        checkOutput("fill_full", req_ready, 0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd6;
        req_wdata = 32'hCAFEF00D;
        repeat (6) tick();
        checkOutput("stall_ready_low", req_ready, 0);
        checkOutput("stall_rsp_valid", rsp_valid, 1);
        checkOutput("stall_rsp_data", rsp_data, 0);
        checkOutput("stall_rsp_err", rsp_err, 1);
        checkOutput("stall_no_strobe", wr_pulses, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("stall_rsp_done", rsp_valid, 0);
        checkOutput("stall_still_full", req_ready, 0);
        tick();
        checkOutput("pop_frees_slot", req_ready, 1);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 100 && busy; i++) tick();
        checkOutput("drain_idle", busy, 0);
        checkOutput("drain_wr_pulses", wr_pulses, 6);
        checkOutput("drain_last_addr", rf_address, 6);
        checkOutput("drain_last_data", rf_in_data, 32'hCAFEF00D);
        checkOutput("drain_log_size", wr_log.size(), 6);
        if (wr_log.size() == 6) begin
            for (int i = 0; i < 5; i++) begin
                checkOutput($sformatf("order_%0d", i), wr_log[i+1], exp_addr[i]);
            end
        end

        $display("[TB] reset during WAIT_RD");
        applyStimulus(1'b0, 4'd8, '0, acc);
        applyStimulus(1'b1, 4'd9, 32'h99999999, acc);
        applyStimulus(1'b1, 4'd10, 32'hAAAAAAAA, acc);
        tick();
        checkOutput("mid_busy", busy, 1);
        checkOutput("mid_rd_pulses", rd_pulses, 3);
        start_wr = wr_pulses;
        start_rd = rd_pulses;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_address", rf_address, 0);
        checkOutput("mid_rst_in_data", rf_in_data, 0);
        checkOutput("mid_rst_rsp_err", rsp_err, 0);
        checkOutput("mid_rst_rsp_valid", rsp_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_ready", req_ready, 1);
        tick();
        rst = 1'b0;
        rf_valid_out = 1'b1;
        rf_out_data  = 32'h77777777;
        tick();
        rf_valid_out = 1'b0;
        rf_out_data  = '0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        checkOutput("post_rst_no_rsp", saw_rsp, 0);
        checkOutput("post_rst_no_wr", wr_pulses, start_wr);
        checkOutput("post_rst_no_rd", rd_pulses, start_rd);
        checkOutput("post_rst_idle", busy, 0);

        $display("[TB] boundary and out-of-range");
        applyStimulus(1'b0, 4'd11, '0, acc);
        tick();
        tick();
        checkOutput("edge_rd_strobe", rf_rd_en, 1);
        checkOutput("edge_rd_address", rf_address, 11);
        tick();
        rf_valid_out = 1'b1;
        rf_out_data  = 32'h0BADF00D;
        tick();
        rf_valid_out = 1'b0;
        rf_out_data  = '0;
        checkOutput("edge_rsp_data", rsp_data, 32'h0BADF00D);
        checkOutput("edge_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        start_rd = rd_pulses;

        applyStimulus(1'b0, 4'd12, '0, acc);
        tick();
        tick();
        checkOutput("oor12_no_strobe", rf_rd_en, 0);
        checkOutput("oor12_rsp_valid", rsp_valid, 1);
        checkOutput("oor12_rsp_err", rsp_err, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        applyStimulus(1'b0, 4'd13, '0, acc);
        tick();
        tick();
        checkOutput("oor13_no_strobe", rf_rd_en, 0);
        checkOutput("oor13_rsp_valid", rsp_valid, 1);
        checkOutput("oor13_rsp_err", rsp_err, 1);
        checkOutput("oor13_rsp_data", rsp_data, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("oor13_rsp_done", rsp_valid, 0);
        checkOutput("oor_rd_pulses", rd_pulses, start_rd);

        start_wr = wr_pulses;
        applyStimulus(1'b1, 4'd14, 32'h12345678, acc);
        tick();
        tick();
        checkOutput("oor14_no_strobe", rf_wr_en, 0);
        checkOutput("oor14_no_rsp", rsp_valid, 0);
        tick();
        checkOutput("oor14_idle", busy, 0);
        checkOutput("oor14_data_hold", rf_in_data, 0);
        checkOutput("oor14_wr_pulses", wr_pulses, start_wr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
